seg7_multi_display: RTL

- Drives NUM_DIGITS active-low 7-segment digits from a DATA_W-bit binary value.
- Two modes: hexadecimal, or decimal using a sequential one-bit-per-cycle double-dabble conversion.
- Optional leading-zero blanking and decimal overflow indication.
- Sits between datapath result registers (e.g. classifier output, cycle counters) and the board HEX displays. It holds the last completed value stable while a new conversion runs.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_glyph_enc.sv | 17 +
 rtl/seg7_multi_display.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared glyph table, controller state encoding and BCD sizing helper
// for the multi-digit seven-segment display driver.
package seg7_pkg;

  // Segment patterns are active-low, bit order g..a.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  // Decimal digits needed for a data_w-bit unsigned value (0.302 > log10(2)).
  function automatic int bcd_digits(input int data_w);
    return (data_w * 302 + 999) / 1000;
  endfunction

endpackage

// File: rtl/seg7_glyph_enc.sv
// One seven-segment digit: nibble to glyph, with dash taking priority over blank.
module seg7_glyph_enc
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] segs
);

  always_comb begin
    segs = SEG_GLYPH[nibble];
    if (blank) segs = SEG_BLANK;
    if (dash)  segs = SEG_DASH;
  end

endmodule

// File: rtl/seg7_multi_display.sv
// Multi-digit seven-segment driver: hex or sequential double-dabble decimal,
// with leading-zero blanking; the display only changes when a conversion completes.
//
// state  | meaning
// IDLE   | display stable, waiting for load
// SHIFT  | double-dabble conversion, one input bit per cycle
// UPDATE | register new segments and overflow, pulse done
module seg7_multi_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       value,
  input  logic                    load,
  input  logic                    dec_mode,
  input  logic                    blank_lz,
  output logic [7*NUM_DIGITS-1:0] hex_segs,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int BCD_DIGITS = bcd_digits(DATA_W);
  // BCD register is never narrower than the display so digit indexing stays in range.
  localparam int BCD_N = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
  localparam int BCD_W = 4 * BCD_N;
  localparam int HEX_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  if (DATA_W < 1 || DATA_W > 4 * NUM_DIGITS) begin : g_bad_param
    $error("seg7_multi_display: DATA_W must be in 1..4*NUM_DIGITS");
  end

  state_t state, state_next;

  logic [DATA_W-1:0]       shreg;
  logic [BCD_W-1:0]        bcd;
  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W+DATA_W-1:0] shift_cat;
  logic [CNT_W-1:0]        cnt;
  logic                    dec_r;
  logic                    lz_r;
  logic [HEX_W-1:0]        hex_ext;
  logic [3:0]              dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    seen;
  logic                    ovf_raw;
  logic                    ovf_dec;
  logic [7*NUM_DIGITS-1:0] seg_next;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = dec_mode ? SHIFT : UPDATE;
      SHIFT:   if (cnt == CNT_W'(1)) state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_N; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign shift_cat = {bcd_adj, shreg} << 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      bcd      <= '0;
      cnt      <= '0;
      dec_r    <= 1'b0;
      lz_r     <= 1'b0;
      hex_segs <= '1;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shreg <= value;
            bcd   <= '0;
            cnt   <= CNT_W'(DATA_W);
            dec_r <= dec_mode;
            lz_r  <= blank_lz;
          end
        end
        SHIFT: begin
          {bcd, shreg} <= shift_cat;
          cnt          <= cnt - 1'b1;
        end
        UPDATE: begin
          hex_segs <= seg_next;
          overflow <= ovf_dec;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // In hex mode shreg still holds the captured value because no shifts ran.
  assign hex_ext = HEX_W'(shreg);

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig[i] = dec_r ? bcd[4*i +: 4] : hex_ext[4*i +: 4];
    end
  end

  always_comb begin
    ovf_raw = 1'b0;
    for (int i = NUM_DIGITS; i < BCD_N; i++) begin
      if (bcd[4*i +: 4] != 4'd0) ovf_raw = 1'b1;
    end
  end

  assign ovf_dec = dec_r & ovf_raw;

  // Scan from the top digit down; digit 0 is always shown.
  always_comb begin
    lz_blank = '0;
    seen     = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (dig[i] != 4'd0) seen = 1'b1;
      lz_blank[i] = lz_r && !seen && (i != 0);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_glyph_enc u_enc (
      .nibble (dig[g]),
      .blank  (lz_blank[g]),
      .dash   (ovf_dec),
      .segs   (seg_next[7*g +: 7])
    );
  end

endmodule
